// File: rtl/siu_niu_pkg.sv
// Shared definitions for the SIU->NIU outbound path: FSM states, bus
// geometry and the per-lane parity function used by both ends of the link.
package siu_niu_pkg;

  localparam int SIO_NIU_BEATS = 4;
  localparam int SIO_NIU_DW    = 128;
  localparam int SIO_NIU_PARW  = 8;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    GAP,
    PAY
  } tx_state_t;

  // Even parity per 16-bit lane: bit i covers data[16i+15:16i].
  function automatic logic [SIO_NIU_PARW-1:0] lane_parity(input logic [SIO_NIU_DW-1:0] d);
    logic [SIO_NIU_PARW-1:0] p;
    p = '0;
    for (int i = 0; i < SIO_NIU_PARW; i++) begin
      p[i] = ^d[16*i +: 16];
    end
    return p;
  endfunction

endpackage

// File: rtl/siu_niu_tx_if.sv
// Outbound SIU->NIU link: header/payload bus plus the NIU credit return.
interface siu_niu_tx_if;
  import siu_niu_pkg::*;

  logic                    sio_niu_hdr_vld;
  logic                    sio_niu_datareq;
  logic [SIO_NIU_DW-1:0]   sio_niu_data;
  logic [SIO_NIU_PARW-1:0] sio_niu_parity;
  logic                    niu_sio_credit;

  modport master (
    output sio_niu_hdr_vld,
    output sio_niu_datareq,
    output sio_niu_data,
    output sio_niu_parity,
    input  niu_sio_credit
  );

  modport slave (
    input  sio_niu_hdr_vld,
    input  sio_niu_datareq,
    input  sio_niu_data,
    input  sio_niu_parity,
    output niu_sio_credit
  );

endinterface

// File: rtl/siu_niu_credit_ctr.sv
// NIU buffer credit counter. Starts full, one credit consumed per accepted
// packet, one returned per NIU pulse. A return while already full saturates
// and latches credit_ovf until reset.
module siu_niu_credit_ctr #(
  parameter int CREDITS = 4
) (
  input  logic clk,
  input  logic rst_l,
  input  logic take,
  input  logic give,
  output logic avail,
  output logic credit_ovf
);

  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] FULL = CW'(CREDITS);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt;

  // Credit count and sticky overflow; take and give together cancel out.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      cnt        <= FULL;
      credit_ovf <= 1'b0;
    end else if (take && !give) begin
      cnt <= cnt - ONE;
    end else if (give && !take) begin
      if (cnt == FULL) begin
        credit_ovf <= 1'b1;
      end else begin
        cnt <= cnt + ONE;
      end
    end
  end

  assign avail = (cnt != '0);

endmodule

// File: rtl/siu_niu_tx.sv
// SIU-side DMA response transmitter. Takes one response per handshake,
// emits a header cycle and, for reads, a gap cycle plus four payload beats.
// All outbound bus signals come straight from flops; the next-cycle values
// are computed one cycle ahead from the next state.
module siu_niu_tx
  import siu_niu_pkg::*;
#(
  parameter int CREDITS = 4,
  parameter int DW      = SIO_NIU_DW
) (
  input  logic                          iol2clk,
  input  logic                          rst_l,
  input  logic                          rsp_vld,
  output logic                          rsp_rdy,
  input  logic [DW-1:0]                 rsp_hdr,
  input  logic                          rsp_has_data,
  input  logic [SIO_NIU_BEATS*DW-1:0]   rsp_data,
  siu_niu_tx_if.master                  niu,
  output logic                          credit_ovf
);

  localparam logic [1:0] LAST_BEAT = 2'(SIO_NIU_BEATS - 1);

  tx_state_t state, state_nxt;
  logic [1:0] beat, beat_nxt;
  logic       has_q;
  logic       accept;
  logic       avail;

  logic [SIO_NIU_BEATS-1:0][DW-1:0] data_q;

  logic                    hdr_vld_nxt;
  logic                    datareq_nxt;
  logic [DW-1:0]           data_nxt;
  logic [SIO_NIU_PARW-1:0] parity_nxt;

  // Ready is forced low while reset is held so nothing is accepted then.
  assign rsp_rdy = rst_l && (state == IDLE) && avail;
  assign accept  = rsp_vld && rsp_rdy;

  siu_niu_credit_ctr #(
    .CREDITS (CREDITS)
  ) u_credit (
    .clk        (iol2clk),
    .rst_l      (rst_l),
    .take       (accept),
    .give       (niu.niu_sio_credit),
    .avail      (avail),
    .credit_ovf (credit_ovf)
  );

  // Payload capture; held until the last beat so upstream is free after accept.
  always_ff @(posedge iol2clk) begin
    if (accept) begin
      data_q <= rsp_data;
    end
  end

  // Next state and the bus values to be shown while in that state.
  always_comb begin
    state_nxt   = state;
    beat_nxt    = beat;
    hdr_vld_nxt = 1'b0;
    datareq_nxt = 1'b0;
    data_nxt    = '0;
    parity_nxt  = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt   = HDR;
          hdr_vld_nxt = 1'b1;
          datareq_nxt = rsp_has_data;
          data_nxt    = rsp_hdr;
        end
      end
      HDR: begin
        state_nxt = has_q ? GAP : IDLE;
      end
      GAP: begin
        state_nxt  = PAY;
        beat_nxt   = 2'd0;
        data_nxt   = data_q[0];
        parity_nxt = lane_parity(data_q[0]);
      end
      PAY: begin
        if (beat == LAST_BEAT) begin
          state_nxt = IDLE;
        end else begin
          beat_nxt   = beat + 2'd1;
          data_nxt   = data_q[beat_nxt];
          parity_nxt = lane_parity(data_q[beat_nxt]);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, beat counter and registered outbound bus; reset aborts any packet.
  always_ff @(posedge iol2clk or negedge rst_l) begin
    if (!rst_l) begin
      state               <= IDLE;
      beat                <= 2'd0;
      has_q               <= 1'b0;
      niu.sio_niu_hdr_vld <= 1'b0;
      niu.sio_niu_datareq <= 1'b0;
      niu.sio_niu_data    <= '0;
      niu.sio_niu_parity  <= '0;
    end else begin
      state               <= state_nxt;
      beat                <= beat_nxt;
      if (accept) begin
        has_q <= rsp_has_data;
      end
      niu.sio_niu_hdr_vld <= hdr_vld_nxt;
      niu.sio_niu_datareq <= datareq_nxt;
      niu.sio_niu_data    <= data_nxt;
      niu.sio_niu_parity  <= parity_nxt;
    end
  end

endmodule
